// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the register-file command sequencer.
package regfile_ctrl_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 8;

  typedef enum logic [2:0] {
    OP_WRITE = 3'd0,
    OP_FILL  = 3'd1,
    OP_COPY  = 3'd2,
    OP_SWAP  = 3'd3,
    OP_SUM   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_FILL  = 3'd2,
    S_SWAP1 = 3'd3,
    S_SWAP2 = 3'd4,
    S_SUM   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Command sequencer owning the register-file write port and both read ports.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [N-1:0]   cmd_a,
  input  logic [N-1:0]   cmd_b,
  input  logic [W-1:0]   cmd_data,
  input  logic [W-1:0]   rand_in,
  output logic           rf_we,
  output logic [N-1:0]   rf_addr_rd,
  output logic [N-1:0]   rf_addr_rs1,
  output logic [N-1:0]   rf_addr_rs2,
  output logic [W-1:0]   rf_data_in,
  input  logic [W-1:0]   rf_rs1,
  input  logic [W-1:0]   rf_rs2,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W+N-1:0] result
);

  state_e           state, state_n;
  logic [2:0]       op_q, op_n;
  logic [N-1:0]     a_q, a_n, b_q, b_n, idx, idx_n;
  logic [W-1:0]     data_q, data_n, tmp, tmp_n;
  logic [W+N-1:0]   acc, acc_n, result_n;
  logic             err_n, we_n;
  logic [N-1:0]     rd_n, rs1_n, rs2_n;

  // Next state plus next values of every registered output.
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    data_n   = data_q;
    idx_n    = idx;
    tmp_n    = tmp;
    acc_n    = acc;
    result_n = result;
    err_n    = 1'b0;
    we_n     = 1'b0;
    rd_n     = '0;
    rs1_n    = '0;
    rs2_n    = '0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_n   = cmd_op;
          a_n    = cmd_a;
          b_n    = cmd_b;
          data_n = cmd_data;
          idx_n  = '0;
          acc_n  = '0;
          case (cmd_op)
            OP_WRITE, OP_COPY: state_n = S_WR;
            OP_FILL:           state_n = S_FILL;
            OP_SWAP:           state_n = S_SWAP1;
            OP_SUM:            state_n = S_SUM;
            default: begin
              state_n = S_DONE;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      S_WR, S_SWAP2: state_n = S_DONE;
      S_SWAP1: begin
        tmp_n   = rf_rs1;
        state_n = S_SWAP2;
      end
      S_FILL: begin
        idx_n = idx + N'(1);
        if (idx == '1) state_n = S_DONE;
      end
      S_SUM: begin
        acc_n = acc + (W+N)'(rf_rs1);
        idx_n = idx + N'(1);
        if (idx == '1) begin
          state_n  = S_DONE;
          result_n = acc_n;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Port drive for the cycle about to start, keyed on the state being entered.
    case (state_n)
      S_WR: begin
        we_n = 1'b1;
        if (op_n == OP_COPY) begin
          rs1_n = a_n;
          rd_n  = b_n;
        end else begin
          rd_n = a_n;
        end
      end
      S_FILL: begin
        we_n = 1'b1;
        rd_n = idx_n;
      end
      S_SWAP1: begin
        we_n  = 1'b1;
        rs1_n = a_n;
        rs2_n = b_n;
        rd_n  = a_n;
      end
      S_SWAP2: begin
        we_n = 1'b1;
        rd_n = b_n;
      end
      S_SUM:   rs1_n = idx_n;
      default: ;
    endcase
  end

  // Write data follows read data and rand_in within the same cycle, so it stays combinational.
  always_comb begin
    rf_data_in = '0;
    case (state)
      S_WR:    rf_data_in = (op_q == OP_COPY) ? rf_rs1 : data_q;
      S_FILL:  rf_data_in = rand_in;
      S_SWAP1: rf_data_in = rf_rs2;
      S_SWAP2: rf_data_in = tmp;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      idx         <= '0;
      tmp         <= '0;
      acc         <= '0;
      result      <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      rf_we       <= 1'b0;
      rf_addr_rd  <= '0;
      rf_addr_rs1 <= '0;
      rf_addr_rs2 <= '0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      a_q         <= a_n;
      b_q         <= b_n;
      data_q      <= data_n;
      idx         <= idx_n;
      tmp         <= tmp_n;
      acc         <= acc_n;
      result      <= result_n;
      err         <= err_n;
      done        <= (state_n == S_DONE);
      busy        <= (state_n != S_IDLE);
      cmd_ready   <= (state_n == S_IDLE);
      rf_we       <= we_n;
      rf_addr_rd  <= rd_n;
      rf_addr_rs1 <= rs1_n;
      rf_addr_rs2 <= rs2_n;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomised bench for regfile_ctrl with a command-level reference model and a bench-side register file.
module tb_regfile_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned NREG = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [2:0]     cmd_op = '0;
  logic [N-1:0]   cmd_a = '0;
  logic [N-1:0]   cmd_b = '0;
  logic [W-1:0]   cmd_data = '0;
  logic [W-1:0]   rand_in = '0;
  logic           rf_we;
  logic [N-1:0]   rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
  logic [W-1:0]   rf_data_in, rf_rs1, rf_rs2;
  logic           busy, done, err;
  logic [W+N-1:0] result;

  always #5 clk = ~clk;

  regfile_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data), .rand_in(rand_in),
    .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_addr_rs1(rf_addr_rs1),
    .rf_addr_rs2(rf_addr_rs2), .rf_data_in(rf_data_in),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  // Bench-side register file: combinational reads, write on the clock edge.
  logic [W-1:0] rf_mem [NREG];
  assign rf_rs1 = rf_mem[rf_addr_rs1];
  assign rf_rs2 = rf_mem[rf_addr_rs2];
  always @(posedge clk) if (rf_we) rf_mem[rf_addr_rd] <= rf_data_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since accept plus architectural effects of each command.
  int             m_k = 0;
  logic [2:0]     m_op = '0;
  logic [N-1:0]   m_a = '0, m_b = '0;
  logic [W-1:0]   m_d = '0;
  logic [W-1:0]   exp_mem [NREG];
  logic [W+N-1:0] exp_result = '0;

  function automatic int dur_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd2: return 2;
      3'd1, 3'd4: return 17;
      3'd3:       return 3;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [W+N-1:0] mem_sum();
    logic [W+N-1:0] s = '0;
    for (int i = 0; i < NREG; i++) s += (W+N)'(exp_mem[i]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k        <= 0;
      exp_result <= '0;
    end else if (m_k == 0) begin
      if (cmd_valid) begin
        m_k  <= 1;
        m_op <= cmd_op;
        m_a  <= cmd_a;
        m_b  <= cmd_b;
        m_d  <= cmd_data;
      end
    end else begin
      if (m_op == 3'd1 && m_k <= 16) exp_mem[4'(m_k - 1)] <= rand_in;
      if (m_k == dur_of(m_op) - 1) begin
        case (m_op)
          3'd0: exp_mem[m_a] <= m_d;
          3'd2: exp_mem[m_b] <= exp_mem[m_a];
          3'd3: begin
            exp_mem[m_a] <= exp_mem[m_b];
            exp_mem[m_b] <= exp_mem[m_a];
          end
          3'd4: exp_result <= mem_sum();
          default: ;
        endcase
      end
      m_k <= (m_k == dur_of(m_op)) ? 0 : m_k + 1;
    end
  end

  // Per-cycle comparison of every handshake and port output against the model.
  always @(negedge clk) begin
    int k, d;
    logic ew;
    logic [N-1:0] erd;
    k  = m_k;
    d  = dur_of(m_op);
    ew = (k != 0) && ((((m_op == 3'd0) || (m_op == 3'd2)) && k == 1) ||
                      ((m_op == 3'd3) && k <= 2) || ((m_op == 3'd1) && k <= 16));
    erd = (m_op == 3'd1) ? 4'(k - 1) :
          (m_op == 3'd2) ? m_b :
          ((m_op == 3'd3) && k == 2) ? m_b : m_a;
    check("cmd_ready", 32'(cmd_ready), 32'(k == 0));
    check("busy", 32'(busy), 32'(k != 0));
    check("done", 32'(done), 32'((k != 0) && (k == d)));
    check("rf_we", 32'(rf_we), 32'(ew));
    check("result", 32'(result), 32'(exp_result));
    if (ew) check("rf_addr_rd", 32'(rf_addr_rd), 32'(erd));
    if ((k != 0) && (k == d)) check("err", 32'(err), 32'(m_op > 3'd4));
    if (k == 0) begin
      check("idle_data_in", 32'(rf_data_in), 32'd0);
      check("idle_rs1", 32'(rf_addr_rs1), 32'd0);
      check("idle_rs2", 32'(rf_addr_rs2), 32'd0);
    end
    if ((m_op == 3'd4) && k >= 1 && k <= 16) check("sum_rs1", 32'(rf_addr_rs1), 32'(k - 1));
  end

  // Cycle counter, write-pulse counter, and last done timestamp for latency checks.
  int   cyc = 0;
  int   we_count = 0;
  int   done_cyc = -1;
  logic done_err = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (rf_we) we_count++;
  end
  always @(negedge clk) if (done) begin
    done_cyc = cyc;
    done_err = err;
  end

  int last_lat, last_we, acc_cyc;

  task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [W-1:0] d, input bit ramp);
    int n, we0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_data  = d;
    acc_cyc   = cyc;
    we0       = we_count;
    @(posedge clk); #1;
    n = 0;
    while (m_k != 0 && n < 40) begin
      cmd_valid = 1'($urandom);
      cmd_op    = 3'($urandom);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_data  = 8'($urandom);
      rand_in   = ramp ? 8'(m_k - 1) + 8'h10 : 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_timeout", 32'(n < 40), 32'd1);
    last_lat = (done_cyc > acc_cyc) ? done_cyc - acc_cyc : -1;
    last_we  = we_count - we0;
  endtask

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < NREG; i++) if (rf_mem[i] !== exp_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(result), 32'd0);

    for (int i = 0; i < NREG; i++) run_cmd(3'd0, 4'(i), 4'd0, 8'($urandom), 1'b0);
    mem_check("preload");

    run_cmd(3'd0, 4'd5, 4'd0, 8'hA7, 1'b0);
    check("write_lat", 32'(last_lat), 32'd2);
    check("write_we", 32'(last_we), 32'd1);
    check("write_reg5", 32'(rf_mem[5]), 32'hA7);

    run_cmd(3'd1, 4'd0, 4'd0, 8'd0, 1'b1);
    check("fill_lat", 32'(last_lat), 32'd17);
    check("fill_we", 32'(last_we), 32'd16);
    check("fill_reg15", 32'(rf_mem[15]), 32'h1F);
    check("fill_reg0", 32'(rf_mem[0]), 32'h10);
    mem_check("fill_mem");

    run_cmd(3'd0, 4'd2, 4'd0, 8'h11, 1'b0);
    run_cmd(3'd0, 4'd9, 4'd0, 8'h22, 1'b0);
    run_cmd(3'd3, 4'd2, 4'd9, 8'd0, 1'b0);
    check("swap_reg2", 32'(rf_mem[2]), 32'h22);
    check("swap_reg9", 32'(rf_mem[9]), 32'h11);
    check("swap_we", 32'(last_we), 32'd2);
    run_cmd(3'd0, 4'd4, 4'd0, 8'h33, 1'b0);
    run_cmd(3'd3, 4'd4, 4'd4, 8'd0, 1'b0);
    check("swap_same_reg4", 32'(rf_mem[4]), 32'h33);

    for (int i = 0; i < NREG; i++) run_cmd(3'd0, 4'(i), 4'd0, 8'hFF, 1'b0);
    run_cmd(3'd4, 4'd0, 4'd0, 8'd0, 1'b0);
    check("sum_result", 32'(result), 32'hFF0);
    check("sum_err", 32'(done_err), 32'd0);
    check("sum_we", 32'(last_we), 32'd0);
    run_cmd(3'd2, 4'd0, 4'd1, 8'd0, 1'b0);
    check("copy_keeps_result", 32'(result), 32'hFF0);
    check("copy_reg1", 32'(rf_mem[1]), 32'hFF);

    run_cmd(3'd6, 4'd3, 4'd7, 8'h5A, 1'b0);
    check("illegal_lat", 32'(last_lat), 32'd1);
    check("illegal_err", 32'(done_err), 32'd1);
    check("illegal_we", 32'(last_we), 32'd0);
    mem_check("illegal_mem");

    // Abort a FILL while it is writing index 6.
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    acc_cyc   = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 40 && m_k != 7; n++) begin
      rand_in = 8'($urandom);
      @(posedge clk); #1;
    end
    check("abort_reached", 32'(m_k), 32'd7);
    rst = 1'b1;
    #1;
    check("abort_we_drop", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_no_done", 32'(done_cyc > acc_cyc), 32'd0);
    bad = 0;
    for (int i = 6; i < NREG; i++) if (rf_mem[i] !== 8'hFF) bad++;
    check("abort_untouched", 32'(bad), 32'd0);
    mem_check("abort_mem");

    for (int t = 0; t < 40; t++) begin
      run_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 8'($urandom), 1'b0);
      mem_check("random_mem");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
